mem_port_arbiter: RTL and testbench

//  Shares the single OTTER memory port between the pipeline's instruction-fetch (IF) and data (MEM-stage) requesters.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// ------------------------------------------------------------------
// mem_port_arbiter_if: fetch / data / memory-port bundle for the arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ------------------------------------------------------------------
// mem_port_arbiter: shares one memory port between fetch and data, data-first with fetch starvation guard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0]          C_STARVE_MAX = 4'(MAX_DSTARVE);
  localparam logic [DATA_W/8-1:0] C_BE_ALL     = '1;
  localparam logic [ADDR_W-1:0]   C_ADDR_ZERO  = '0;
  localparam logic [DATA_W-1:0]   C_DATA_ZERO  = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_IF = 2'd1,
    ST_RD_D  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       r_frz_vld;
  logic       r_frz_d;
  logic       w_frz_vld_nxt;
  logic       w_frz_d_nxt;

  logic       w_rsp;
  logic       w_can_issue;
  logic       w_sel_d;
  logic       w_mem_en;
  logic       w_grant;
  logic       w_d_gnt;
  logic       w_if_gnt;
  logic       w_if_rvalid;
  logic       w_d_rvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 4'd0;
      r_frz_vld    <= 1'b0;
      r_frz_d      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_frz_vld    <= w_frz_vld_nxt;
      r_frz_d      <= w_frz_d_nxt;
    end
  end

  always_comb begin
    w_rsp       = (r_state != ST_IDLE) && bus.mem_rvalid;
    // A response in flight frees the port in the same cycle (back-to-back issue)
    w_can_issue = !rst && ((r_state == ST_IDLE) || w_rsp);

    // A stalled request keeps its winner until memory accepts it
    if (r_frz_vld) begin
      w_sel_d = r_frz_d;
    end else begin
      w_sel_d = bus.d_req && !(bus.if_req && (r_starve_cnt == C_STARVE_MAX));
    end

    w_mem_en = w_can_issue && (w_sel_d ? bus.d_req : bus.if_req);
    w_grant  = w_mem_en && bus.mem_ready;
    w_d_gnt  = w_grant && w_sel_d;
    w_if_gnt = w_grant && !w_sel_d;

    w_if_rvalid = w_rsp && (r_state == ST_RD_IF);
    w_d_rvalid  = w_rsp && (r_state == ST_RD_D);

    w_frz_vld_nxt = w_mem_en && !bus.mem_ready;
    w_frz_d_nxt   = w_sel_d;

    w_state_nxt = r_state;
    if (w_grant) begin
      if (w_sel_d) begin
        w_state_nxt = bus.d_we ? ST_IDLE : ST_RD_D;
      end else begin
        w_state_nxt = ST_RD_IF;
      end
    end else if (w_rsp) begin
      w_state_nxt = ST_IDLE;
    end

    w_starve_nxt = r_starve_cnt;
    if (!bus.if_req || w_if_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (w_d_gnt && (r_starve_cnt != C_STARVE_MAX)) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.d_rvalid  = w_d_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : C_DATA_ZERO;
  assign bus.d_rdata   = w_d_rvalid  ? bus.mem_rdata : C_DATA_ZERO;

  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_en && w_sel_d && bus.d_we;
  assign bus.mem_addr  = !w_mem_en ? C_ADDR_ZERO : (w_sel_d ? bus.d_addr : bus.if_addr);
  assign bus.mem_wdata = (w_mem_en && w_sel_d) ? bus.d_wdata : C_DATA_ZERO;
  assign bus.mem_be    = !w_mem_en ? '0 : (w_sel_d ? bus.d_be : C_BE_ALL);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ------------------------------------------------------------------
// tb_mem_port_arbiter: directed scenarios then randomized traffic against a memory model and scoreboard
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTARVE(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] if_q[$];
  logic [31:0] d_q[$];
  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  bit          env_stop = 1'b0;
  int          dstreak  = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: grant attributes, routed read data, starvation bound
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        dstreak = 0;
      end else begin
        if (bus.if_gnt || bus.d_gnt)
          chk("single_gnt", {31'd0, bus.if_gnt & bus.d_gnt}, 32'd0);
        if ((bus.if_gnt || bus.d_gnt) && bus.if_req && dstreak == MAXS)
          chk("starve_guard_fetch_wins", {31'd0, bus.if_gnt}, 32'd1);
        if (bus.if_gnt) begin
          chk("if_mem_addr", bus.mem_addr, bus.if_addr);
          chk("if_mem_be", {28'd0, bus.mem_be}, 32'hF);
          chk("if_mem_we", {31'd0, bus.mem_we}, 32'd0);
        end
        if (bus.d_gnt) begin
          chk("d_mem_addr", bus.mem_addr, bus.d_addr);
          chk("d_mem_we", {31'd0, bus.mem_we}, {31'd0, bus.d_we});
          if (bus.d_we) begin
            chk("d_mem_wdata", bus.mem_wdata, bus.d_wdata);
            chk("d_mem_be", {28'd0, bus.mem_be}, {28'd0, bus.d_be});
          end
        end
        if (bus.if_rvalid) begin
          if (if_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL if_rvalid_unexpected: got if_rvalid=1 expected 0");
          end else chk("if_rdata", bus.if_rdata, if_q.pop_front());
        end
        if (bus.d_rvalid) begin
          if (d_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL d_rvalid_unexpected: got d_rvalid=1 expected 0");
          end else chk("d_rdata", bus.d_rdata, d_q.pop_front());
        end
        if (bus.d_gnt && bus.if_req) begin
          dstreak++;
          tests++;
          if (dstreak > MAXS) begin
            fails++;
            $display("FAIL starve_bound: got %0d data grants expected at most %0d", dstreak, MAXS);
          end
        end else if (bus.if_gnt || !bus.if_req) begin
          dstreak = 0;
        end
      end
    end
  end

  // Memory model with random stalls, latency 1..3 and spurious idle rvalids
  task automatic mem_env();
    bit          pend  = 1'b0;
    int          waitc = 0;
    logic [31:0] pdata = 32'd0;
    logic [31:0] a;
    while (!env_stop) begin
      if (pend && waitc == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = pdata;
        pend = 1'b0;
      end else begin
        bus.mem_rvalid = !pend && ($urandom_range(0, 7) == 0);
        bus.mem_rdata  = $urandom;
        if (pend) waitc--;
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.mem_en && bus.mem_ready) begin
        a = bus.mem_addr;
        if (bus.mem_we) begin
          env_mem[a] = merge(env_mem.exists(a) ? env_mem[a] : init_word(a), bus.mem_wdata, bus.mem_be);
        end else begin
          pend  = 1'b1;
          waitc = $urandom_range(0, 2);
          pdata = env_mem.exists(a) ? env_mem[a] : init_word(a);
        end
      end
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_ready  = 1'b1;
  endtask

  task automatic if_driver(input int n);
    int idle;
    int w;
    for (int k = 0; k < n; k++) begin
      bus.if_req = 1'b0;
      idle = $urandom_range(0, 2);
      repeat (idle) tick();
      bus.if_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      bus.if_req  = 1'b1;
      if_q.push_back(init_word(bus.if_addr));
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.if_gnt && w < 300);
      if (!bus.if_gnt) begin
        tests++; fails++;
        $display("FAIL if_gnt_timeout: got no grant after %0d cycles expected a grant", w);
      end
      tick();
    end
    bus.if_req = 1'b0;
  endtask

  task automatic d_driver(input int n);
    int          idle;
    int          w;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      bus.d_req = 1'b0;
      idle = $urandom_range(0, 3);
      repeat (idle) tick();
      a = 32'h2000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      bus.d_addr  = a;
      bus.d_we    = 1'($urandom_range(0, 1));
      bus.d_be    = 4'($urandom_range(1, 15));
      bus.d_wdata = $urandom;
      bus.d_req   = 1'b1;
      if (bus.d_we)
        ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : init_word(a), bus.d_wdata, bus.d_be);
      else
        d_q.push_back(ref_mem.exists(a) ? ref_mem[a] : init_word(a));
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!bus.d_gnt && w < 300);
      if (!bus.d_gnt) begin
        tests++; fails++;
        $display("FAIL d_gnt_timeout: got no grant after %0d cycles expected a grant", w);
      end
      tick();
    end
    bus.d_req = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h48; bus.d_wdata = 32'd0; bus.d_be = 4'hF;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;

    // Reset: outputs quiet even with requests and rvalid present
    tick(); tick();
    @(negedge clk);
    chk("reset_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("reset_gnts", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd0);
    chk("reset_rvalids", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
    tick();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_spurious_rvalid", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
    chk("idle_mem_en", {31'd0, bus.mem_en}, 32'd0);

    // Single fetch, latency 1
    tick();
    bus.mem_rvalid = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    if_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("t2_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
    tick();
    bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);

    // Simultaneous requests: data first, fetch on the data response cycle
    tick();
    bus.mem_rvalid = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
    d_q.push_back(32'h11112222);
    if_q.push_back(32'h33334444);
    @(negedge clk);
    chk("t3_d_first", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd1);
    tick();
    bus.d_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h11112222;
    @(negedge clk);
    chk("t3_d_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("t3_if_gnt_on_rsp", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd2);
    tick();
    bus.if_req = 1'b0; bus.mem_rdata = 32'h33334444;
    @(negedge clk);
    chk("t3_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);

    // Continuous writes versus a waiting fetch
    tick();
    bus.mem_rvalid = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h3000; bus.d_wdata = 32'hA5A5A5A5; bus.d_be = 4'h3;
    bus.if_req = 1'b1; bus.if_addr = 32'h108;
    if_q.push_back(32'h55556666);
    for (int k = 0; k < MAXS; k++) begin
      @(negedge clk);
      chk($sformatf("t4_d_gnt_%0d", k), {30'd0, bus.if_gnt, bus.d_gnt}, 32'd1);
      tick();
    end
    @(negedge clk);
    chk("t4_if_gnt", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd2);
    tick();
    bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55556666;
    @(negedge clk);
    chk("t4_d_resumes", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd1);
    chk("t4_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);

    // Stalled memory: request held, data still wins once accepted
    tick();
    bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b0;
    bus.d_we = 1'b0; bus.d_addr = 32'h2004; bus.d_be = 4'hF;
    d_q.push_back(32'h77778888);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5_stall_addr_%0d", k), bus.mem_addr, 32'h2004);
      chk($sformatf("t5_stall_nognt_%0d", k), {30'd0, bus.if_gnt, bus.d_gnt}, 32'd0);
      tick();
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h10C;
    if_q.push_back(32'h9999AAAA);
    @(negedge clk);
    chk("t5_addr_hold", bus.mem_addr, 32'h2004);
    tick();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("t5_d_first", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd1);
    tick();
    bus.d_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77778888;
    @(negedge clk);
    chk("t5_if_gnt", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd2);
    tick();
    bus.if_req = 1'b0; bus.mem_rdata = 32'h9999AAAA;
    @(negedge clk);
    chk("t5_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);

    // Reset while a data read is outstanding; late response ignored
    tick();
    bus.mem_rvalid = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2008;
    @(negedge clk);
    chk("t6_d_gnt", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd1);
    tick();
    bus.d_req = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000CAFE;
    @(negedge clk);
    chk("t6_late_rvalid_ignored", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h110;
    if_q.push_back(32'h12345678);
    @(negedge clk);
    chk("t6_if_gnt", {30'd0, bus.if_gnt, bus.d_gnt}, 32'd2);
    tick();
    bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("t6_if_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
    tick();
    bus.mem_rvalid = 1'b0;

    // Randomized concurrent traffic
    fork
      mem_env();
    join_none
    fork
      if_driver(150);
      d_driver(150);
    join
    w = 0;
    while ((if_q.size() != 0 || d_q.size() != 0) && w < 100) begin
      tick();
      w++;
    end
    chk("drain_if_q", if_q.size(), 32'd0);
    chk("drain_d_q", d_q.size(), 32'd0);
    env_stop = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
